toggle_scheduler: RTL and testbench

Programmable edge generator: accepts toggle commands, each carrying a delay, and toggles a single-bit output level once per command after that delay expires. It produces the waveforms that the Mealy and Moore edge detectors consume. For loopback checking it also emits one-cycle rising and falling strobes aligned to each toggle. Commands are buffered in a small FIFO so toggles can be scheduled back-to-back without gaps.

---
 rtl/edge_pkg.sv | 12 +
 rtl/toggle_scheduler_if.sv | 28 ++
 rtl/toggle_scheduler_sync_fifo.sv | 65 ++++++
 rtl/toggle_scheduler.sv | 84 ++++++++
 tb/tb_toggle_scheduler.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_pkg.sv
// Shared FSM state type and default sizing for the toggle scheduler.
package edge_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  localparam int DELAY_W_DEF = 7;
  localparam int DEPTH_DEF   = 4;

endpackage

// File: rtl/toggle_scheduler_if.sv
// Command/waveform bundle between a command source and the toggle scheduler.
interface toggle_scheduler_if
  import edge_pkg::*;
#(
  parameter int DELAY_W = DELAY_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
);

  logic [DELAY_W-1:0]         cmd_delay;
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       level;
  logic                       rise;
  logic                       fall;
  logic                       busy;
  logic [$clog2(DEPTH+1)-1:0] pending;

  modport master (
    output cmd_delay, cmd_valid,
    input  cmd_ready, level, rise, fall, busy, pending
  );

  modport slave (
    input  cmd_delay, cmd_valid,
    output cmd_ready, level, rise, fall, busy, pending
  );

endinterface

// File: rtl/toggle_scheduler_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is always visible on rd_data.
module sync_fifo
  import edge_pkg::*;
#(
  parameter int WIDTH = DELAY_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // A write while full is dropped even if a read happens in the same cycle.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_rd) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (do_wr && !do_rd) begin
        count <= count + CNT_W'(1);
      end else if (do_rd && !do_wr) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/toggle_scheduler.sv
// Programmable edge generator: each queued command toggles level after D+1 counting cycles,
// with one-cycle rise/fall strobes aligned to every scheduled toggle.
module toggle_scheduler
  import edge_pkg::*;
#(
  parameter int   DELAY_W    = DELAY_W_DEF,
  parameter int   DEPTH      = DEPTH_DEF,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  toggle_scheduler_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  state_t             state;
  logic [DELAY_W-1:0] cnt;
  logic [DELAY_W-1:0] head_delay;
  logic               level_q;
  logic               rise_q;
  logic               fall_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               expire;
  logic               push;
  logic               pop;

  // The next command is popped either from idle or on the very edge the current one expires,
  // so chained commands run with no gap between them.
  assign expire = (state == S_COUNT) && (cnt == '0);
  assign pop    = !fifo_empty && ((state == S_IDLE) || expire);
  assign push   = bus.cmd_valid && !fifo_full;

  sync_fifo #(
    .WIDTH (DELAY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (bus.cmd_delay),
    .rd_en   (pop),
    .rd_data (head_delay),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (expire) begin
        level_q <= !level_q;
        rise_q  <= !level_q;
        fall_q  <= level_q;
      end else if (state == S_COUNT) begin
        cnt <= cnt - DELAY_W'(1);
      end
      if (pop) begin
        state <= S_COUNT;
        cnt   <= head_delay;
      end else if (expire) begin
        state <= S_IDLE;
      end
    end
  end

  assign bus.level     = level_q;
  assign bus.rise      = rise_q;
  assign bus.fall      = fall_q;
  assign bus.busy      = (state == S_COUNT);
  assign bus.cmd_ready = !fifo_full;
  assign bus.pending   = fifo_count;

endmodule

// File: tb/tb_toggle_scheduler.sv
// Bench for toggle_scheduler: timeline-based reference model, directed timing pins,
// and a randomized loopback run through Mealy/Moore edge detectors.
module tb_toggle_scheduler;
  import edge_pkg::*;

  localparam int   DELAY_W    = 7;
  localparam int   DEPTH      = 4;
  localparam logic INIT_LEVEL = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  toggle_scheduler_if #(.DELAY_W(DELAY_W), .DEPTH(DEPTH)) bus ();

  toggle_scheduler #(
    .DELAY_W    (DELAY_W),
    .DEPTH      (DEPTH),
    .INIT_LEVEL (INIT_LEVEL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: commands wait in a queue; the executing one is described only by the
  // absolute edge number at which it must toggle.
  int   cyc        = 0;
  int   m_q[$];
  bit   m_active   = 1'b0;
  int   m_toggle_at = 0;
  logic m_level    = INIT_LEVEL;
  logic m_rise     = 1'b0;
  logic m_fall     = 1'b0;
  int   acc_cnt    = 0;
  bit   m_push;

  int   strobe_cnt = 0;
  int   strobe_cyc[$];
  bit   strobe_rise[$];

  bit   loop_on = 1'b0;
  int   dut_ev[$];
  int   mealy_ev[$];
  int   moore_ev[$];
  logic prev_level = INIT_LEVEL;
  logic moore_rise = 1'b0;
  logic moore_fall = 1'b0;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic report_timeout(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_active = 1'b0;
      m_level  = INIT_LEVEL;
      m_rise   = 1'b0;
      m_fall   = 1'b0;
      cyc      = 0;
      acc_cnt  = 0;
    end else begin
      m_push = bus.cmd_valid && (m_q.size() < DEPTH);
      cyc++;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (m_active && cyc == m_toggle_at) begin
        m_level = !m_level;
        m_rise  = m_level;
        m_fall  = !m_level;
        if (m_q.size() > 0) m_toggle_at = cyc + m_q.pop_front() + 1;
        else                m_active    = 1'b0;
      end else if (!m_active && m_q.size() > 0) begin
        m_toggle_at = cyc + m_q.pop_front() + 1;
        m_active    = 1'b1;
      end
      if (m_push) begin
        m_q.push_back(int'(bus.cmd_delay));
        acc_cnt++;
      end
    end
  end

  // Moore-style detector: registered pulse one cycle after the level change.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_level <= INIT_LEVEL;
      moore_rise <= 1'b0;
      moore_fall <= 1'b0;
    end else begin
      moore_rise <= bus.level & ~prev_level;
      moore_fall <= ~bus.level & prev_level;
      prev_level <= bus.level;
    end
  end

  always @(negedge clk) begin
    check_output("level",     int'(bus.level),     int'(m_level));
    check_output("rise",      int'(bus.rise),      int'(m_rise));
    check_output("fall",      int'(bus.fall),      int'(m_fall));
    check_output("busy",      int'(bus.busy),      int'(m_active));
    check_output("cmd_ready", int'(bus.cmd_ready), int'(m_q.size() < DEPTH));
    check_output("pending",   int'(bus.pending),   m_q.size());
    if (rst) begin
      strobe_cnt = 0;
    end else if (bus.rise || bus.fall) begin
      strobe_cnt++;
      strobe_cyc.push_back(cyc);
      strobe_rise.push_back(bus.rise);
    end
    if (loop_on) begin
      if (bus.rise) dut_ev.push_back(cyc * 2 + 1);
      if (bus.fall) dut_ev.push_back(cyc * 2);
      if (bus.level & ~prev_level) mealy_ev.push_back(cyc * 2 + 1);
      if (~bus.level & prev_level) mealy_ev.push_back(cyc * 2);
      if (moore_rise) moore_ev.push_back(cyc * 2 + 1);
      if (moore_fall) moore_ev.push_back(cyc * 2);
    end
  end

  // Offers one command and holds it until accepted; returns just after the accepting edge.
  task automatic apply_stimulus(input int d, input int max_wait);
    bit ok = 1'b0;
    bus.cmd_delay = DELAY_W'(d);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    if (!ok) report_timeout("cmd_accept");
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || bus.pending != 0) && n < bound);
    if (bus.busy || bus.pending != 0) report_timeout("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a;
    bus.cmd_valid = 1'b0;
    bus.cmd_delay = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    check_output("rst_level", int'(bus.level), int'(INIT_LEVEL));
    check_output("rst_rise",  int'(bus.rise),  0);
    check_output("rst_busy",  int'(bus.busy),  0);
    check_output("rst_ready", int'(bus.cmd_ready), 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single D=5 command accepted at edge 10: toggle at 17, busy over edges 11..16.
    while (cyc < 9) begin
      @(posedge clk);
      #1;
    end
    apply_stimulus(5, 10);
    check_output("acc_edge", cyc, 10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("d5_busy",  int'(bus.busy),  int'(cyc >= 11 && cyc < 17));
      check_output("d5_level", int'(bus.level), int'(cyc >= 17));
      check_output("d5_rise",  int'(bus.rise),  int'(cyc == 17));
    end
    wait_idle(50);

    // Back-to-back D = 3, 0, 2 from level 1: fall, rise, fall spaced 4 (from pop), 1, 3.
    strobe_cyc.delete();
    strobe_rise.delete();
    apply_stimulus(3, 10);
    a = cyc;
    apply_stimulus(0, 10);
    apply_stimulus(2, 10);
    wait_idle(50);
    check_output("b2b_count", strobe_cyc.size(), 3);
    if (strobe_cyc.size() == 3) begin
      check_output("b2b_first", strobe_cyc[0] - (a + 1), 4);
      check_output("b2b_gap1",  strobe_cyc[1] - strobe_cyc[0], 1);
      check_output("b2b_gap2",  strobe_cyc[2] - strobe_cyc[1], 3);
      check_output("b2b_type0", int'(strobe_rise[0]), 0);
      check_output("b2b_type1", int'(strobe_rise[1]), 1);
      check_output("b2b_type2", int'(strobe_rise[2]), 0);
    end

    // FIFO full: DEPTH+2 commands offered back to back.
    for (int i = 0; i < DEPTH + 2; i++) begin
      apply_stimulus(20, 300);
      if (i == DEPTH) begin
        @(negedge clk);
        check_output("full_pending", int'(bus.pending),   DEPTH);
        check_output("full_ready",   int'(bus.cmd_ready), 0);
        @(posedge clk);
        #1;
      end
    end
    wait_idle(1000);

    // Maximum delay: toggle 128 cycles after the pop.
    strobe_cyc.delete();
    strobe_rise.delete();
    apply_stimulus(127, 10);
    a = cyc;
    wait_idle(300);
    check_output("max_count", strobe_cyc.size(), 1);
    if (strobe_cyc.size() == 1) check_output("max_delay", strobe_cyc[0] - (a + 1), 128);

    // Reset mid-operation with two commands queued and level high.
    apply_stimulus(30, 10);
    apply_stimulus(30, 10);
    apply_stimulus(30, 10);
    idle_cycles(2);
    @(negedge clk);
    check_output("pre_rst_pending", int'(bus.pending), 2);
    check_output("pre_rst_busy",    int'(bus.busy),    1);
    check_output("pre_rst_level",   int'(bus.level),   1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_output("mid_rst_level",   int'(bus.level),     0);
    check_output("mid_rst_fall",    int'(bus.fall),      0);
    check_output("mid_rst_pending", int'(bus.pending),   0);
    check_output("mid_rst_ready",   int'(bus.cmd_ready), 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // After release: D=2 accepted at edge 1 toggles (rising) at edge 5.
    strobe_cyc.delete();
    strobe_rise.delete();
    apply_stimulus(2, 10);
    wait_idle(50);
    check_output("post_rst_count", strobe_cyc.size(), 1);
    if (strobe_cyc.size() == 1) begin
      check_output("post_rst_edge", strobe_cyc[0], 5);
      check_output("post_rst_rise", int'(strobe_rise[0]), 1);
    end

    // Randomized loopback through both edge detectors.
    idle_cycles(3);
    loop_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle_cycles($urandom_range(0, 3));
      apply_stimulus($urandom_range(0, 127), 300);
    end
    wait_idle(2000);
    idle_cycles(3);
    loop_on = 1'b0;
    check_output("loop_toggles", dut_ev.size(), 10);
    check_output("loop_mealy_n", mealy_ev.size(), dut_ev.size());
    check_output("loop_moore_n", moore_ev.size(), dut_ev.size());
    for (int i = 0; i < dut_ev.size(); i++) begin
      if (i < mealy_ev.size()) check_output("loop_mealy_ev", mealy_ev[i], dut_ev[i]);
      if (i < moore_ev.size()) check_output("loop_moore_ev", moore_ev[i], dut_ev[i] + 2);
    end

    check_output("toggles_per_accept", strobe_cnt, acc_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
